// File: rtl/sbr_pkg.sv
// Shared types and constants for the SN74LS165 serial frame receiver.
package sbr_pkg;

  // Default frame length: a single SN74LS165.
  localparam int unsigned SBR_DEFAULT_WIDTH = 8;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sbr_state_t;

  // Bit counter width: must hold the value WIDTH itself so it never wraps.
  function automatic int unsigned sbr_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sbr_if.sv
// Frame delivery handshake: Data/Valid from the receiver, Ready from the consumer.
interface sbr_if
  import sbr_pkg::*;
#(
  parameter int unsigned WIDTH = SBR_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] Data;
  logic             Valid;
  logic             Ready;

  modport master (output Data, output Valid, input Ready);
  modport slave  (input Data, input Valid, output Ready);

endinterface

// File: rtl/sbr_shift_capture.sv
// Capture datapath: input conditioning, MSB-first shift register and bit counter.
module sbr_shift_capture
  import sbr_pkg::*;
#(
  parameter int unsigned  WIDTH     = SBR_DEFAULT_WIDTH,
  parameter bit           INVERT_IN = 1'b0,
  localparam int unsigned CW        = sbr_cnt_width(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] shift_reg,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic serial_bit;

  // Undo the inversion of the Q7b tap so the register always sees true data.
  always_comb begin
    serial_bit = SerialIn ^ INVERT_IN;
  end

  // Shift the conditioned bit in at the LSB; the first bit ends up in the MSB.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WIDTH-2:0], serial_bit};
      if (bit_cnt != CNT_MAX) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_byte_receiver.sv
// SN74LS165 frame receiver: sequences PL_n/ClkInh, captures WIDTH bits MSB first
// and presents each frame on a Valid/Ready handshake with sticky overrun.
module serial_byte_receiver
  import sbr_pkg::*;
#(
  parameter int unsigned WIDTH     = SBR_DEFAULT_WIDTH,
  parameter bit          INVERT_IN = 1'b0
) (
  input  logic  Clock,
  input  logic  Reset_n,
  input  logic  Start,
  input  logic  SerialIn,
  output logic  PL_n,
  output logic  ClkInh,
  output logic  Busy,
  output logic  Overrun,
  input  logic  ClearOvr,
  sbr_if.master frame_bus
);

  localparam int unsigned   CW       = sbr_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sbr_state_t       state;
  sbr_state_t       state_next;
  logic             start_q;
  logic             load_phase;
  logic             shift_phase;
  logic             deliver;
  logic             transfer;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  sbr_shift_capture #(
    .WIDTH     (WIDTH),
    .INVERT_IN (INVERT_IN)
  ) u_capture (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .clear     (load_phase),
    .shift_en  (shift_phase),
    .SerialIn  (SerialIn),
    .shift_reg (shift_reg),
    .bit_cnt   (bit_cnt)
  );

  // Start is registered, and only while idle, so requests raised during a
  // capture are dropped and the extra stage sets the Start-to-Valid latency.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= Start && (state == IDLE);
    end
  end

  // Sequencer state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and shift-register control pins.
  always_comb begin
    state_next  = state;
    PL_n        = 1'b1;
    ClkInh      = 1'b1;
    Busy        = 1'b1;
    load_phase  = 1'b0;
    shift_phase = 1'b0;
    deliver     = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (start_q) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        PL_n       = 1'b0;
        load_phase = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        shift_phase = 1'b1;
        ClkInh      = !(bit_cnt < LAST_BIT);
        if (bit_cnt == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        deliver    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    transfer = valid_q && frame_bus.Ready;
  end

  // Output register: accept a new frame when empty or being drained, else drop it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (deliver && (!valid_q || frame_bus.Ready)) begin
      data_q  <= shift_reg;
      valid_q <= 1'b1;
    end else if (transfer) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle as ClearOvr keeps the flag set.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Overrun <= 1'b0;
    end else if (deliver && valid_q && !frame_bus.Ready) begin
      Overrun <= 1'b1;
    end else if (ClearOvr) begin
      Overrun <= 1'b0;
    end
  end

  assign frame_bus.Data  = data_q;
  assign frame_bus.Valid = valid_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: three instances (8-bit, 8-bit on Q7b, 16-bit
// cascade) each fed by behavioural SN74LS165 shift registers.
module tb_serial_byte_receiver;

  logic Clock = 1'b0;
  logic Reset_n;
  logic [2:0] start_v;
  logic [2:0] ready_v;
  logic [2:0] clr_v;

  always #5 Clock = ~Clock;

  // ---------------- instance A: WIDTH=8, Q7 tap ----------------
  sbr_if #(.WIDTH(8)) bus_a ();
  logic pl_a, inh_a, busy_a, ovr_a, sin_a;
  logic [7:0] p_a, q_a;

  serial_byte_receiver #(.WIDTH(8), .INVERT_IN(1'b0)) dut_a (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start_v[0]), .SerialIn(sin_a),
    .PL_n(pl_a), .ClkInh(inh_a), .Busy(busy_a), .Overrun(ovr_a),
    .ClearOvr(clr_v[0]), .frame_bus(bus_a)
  );
  assign bus_a.Ready = ready_v[0];
  assign sin_a = q_a[7];

  always @(posedge Clock or negedge pl_a)
    if (!pl_a) q_a <= p_a;
    else if (!inh_a) q_a <= {q_a[6:0], 1'b0};

  // ---------------- instance B: WIDTH=8, Q7b tap ----------------
  sbr_if #(.WIDTH(8)) bus_b ();
  logic pl_b, inh_b, busy_b, ovr_b, sin_b;
  logic [7:0] p_b, q_b;

  serial_byte_receiver #(.WIDTH(8), .INVERT_IN(1'b1)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start_v[1]), .SerialIn(sin_b),
    .PL_n(pl_b), .ClkInh(inh_b), .Busy(busy_b), .Overrun(ovr_b),
    .ClearOvr(clr_v[1]), .frame_bus(bus_b)
  );
  assign bus_b.Ready = ready_v[1];
  assign sin_b = ~q_b[7];

  always @(posedge Clock or negedge pl_b)
    if (!pl_b) q_b <= p_b;
    else if (!inh_b) q_b <= {q_b[6:0], 1'b0};

  // ---------------- instance C: WIDTH=16, two cascaded chips ----------------
  sbr_if #(.WIDTH(16)) bus_c ();
  logic pl_c, inh_c, busy_c, ovr_c, sin_c;
  logic [15:0] p_c;
  logic [7:0] q_c1, q_c2;

  serial_byte_receiver #(.WIDTH(16), .INVERT_IN(1'b0)) dut_c (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start_v[2]), .SerialIn(sin_c),
    .PL_n(pl_c), .ClkInh(inh_c), .Busy(busy_c), .Overrun(ovr_c),
    .ClearOvr(clr_v[2]), .frame_bus(bus_c)
  );
  assign bus_c.Ready = ready_v[2];
  assign sin_c = q_c1[7];

  // chip 1 feeds the receiver; chip 2 feeds chip 1's DS input
  always @(posedge Clock or negedge pl_c)
    if (!pl_c) q_c1 <= p_c[15:8];
    else if (!inh_c) q_c1 <= {q_c1[6:0], q_c2[7]};

  always @(posedge Clock or negedge pl_c)
    if (!pl_c) q_c2 <= p_c[7:0];
    else if (!inh_c) q_c2 <= {q_c2[6:0], 1'b0};

  // ---------------- per-instance views ----------------
  logic [15:0] d_v [3];
  logic [2:0] v_v, pl_v, inh_v, busy_v, ovr_v;

  assign d_v[0] = {8'h00, bus_a.Data};
  assign d_v[1] = {8'h00, bus_b.Data};
  assign d_v[2] = bus_c.Data;
  assign v_v    = {bus_c.Valid, bus_b.Valid, bus_a.Valid};
  assign pl_v   = {pl_c, pl_b, pl_a};
  assign inh_v  = {inh_c, inh_b, inh_a};
  assign busy_v = {busy_c, busy_b, busy_a};
  assign ovr_v  = {ovr_c, ovr_b, ovr_a};

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    int unsigned dut;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int unsigned w, input logic [15:0] data);
    exp_t e;
    e.dut = w;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int unsigned w, input string tag);
    exp_t e;
    check({tag, ".sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".sb_dut"}, e.dut, w);
      check({tag, ".data"}, 32'(d_v[w]), 32'(e.data));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Start is high across exactly one rising edge; returns 1 time unit after it.
  task automatic pulse_start(input int unsigned w);
    @(negedge Clock);
    start_v[w] = 1'b1;
    @(posedge Clock);
    #1;
    start_v[w] = 1'b0;
  endtask

  // Follow one capture to its Valid edge, checking latency and pin activity.
  task automatic wait_frame(input int unsigned w, input int unsigned exp_lat, input string tag);
    int unsigned edges = 0;
    int unsigned pl_lo = 0;
    int unsigned inh_lo = 0;
    int unsigned busy_hi = 0;
    int unsigned wd = (w == 2) ? 16 : 8;
    bit seen = 1'b0;
    while (!seen && edges < 40) begin
      tick();
      edges++;
      if (!pl_v[w]) pl_lo++;
      if (!inh_v[w]) inh_lo++;
      if (busy_v[w]) busy_hi++;
      if (v_v[w]) seen = 1'b1;
    end
    check({tag, ".valid_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, edges, exp_lat);
    check({tag, ".pl_cycles"}, pl_lo, 32'd1);
    check({tag, ".clkinh_low_cycles"}, inh_lo, wd - 1);
    check({tag, ".busy_cycles"}, busy_hi, wd + 2);
    sb_pop(w, tag);
  endtask

  task automatic wait_overrun(input int unsigned exp_lat, input string tag);
    int unsigned edges = 0;
    bit seen = 1'b0;
    while (!seen && edges < 40) begin
      tick();
      edges++;
      if (ovr_v[0]) seen = 1'b1;
    end
    check({tag, ".ovr_seen"}, 32'(seen), 32'd1);
    check({tag, ".ovr_latency"}, edges, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pulses;
    int unsigned frames;
    int unsigned vcount;
    bit idle_seen;

    Reset_n = 1'b0;
    start_v = '0;
    ready_v = '0;
    clr_v   = '0;
    p_a = 8'h00;
    p_b = 8'h00;
    p_c = 16'h0000;

    // reset values
    repeat (3) @(negedge Clock);
    check("rst.pl_n", 32'(pl_a), 32'd1);
    check("rst.clkinh", 32'(inh_a), 32'd1);
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.valid", 32'(v_v), 32'd0);
    check("rst.data", 32'(d_v[0]), 32'd0);
    check("rst.data16", 32'(d_v[2]), 32'd0);
    check("rst.overrun", 32'(ovr_v), 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);

    // basic capture, consumer always ready
    p_a = 8'hA1;
    ready_v[0] = 1'b1;
    pulse_start(0);
    sb_push(0, 16'h00A1);
    wait_frame(0, 11, "basic");
    tick();
    check("basic.valid_one_cycle", 32'(v_v[0]), 32'd0);
    check("basic.no_overrun", 32'(ovr_v[0]), 32'd0);

    // held frame, second frame dropped
    ready_v[0] = 1'b0;
    repeat (2) tick();
    pulse_start(0);
    sb_push(0, 16'h00A1);
    wait_frame(0, 11, "hold1");
    p_a = 8'h5E;
    pulse_start(0);
    wait_overrun(11, "drop");
    check("drop.data_kept", 32'(d_v[0]), 32'h0000_00A1);
    check("drop.valid_kept", 32'(v_v[0]), 32'd1);
    @(negedge Clock);
    clr_v[0] = 1'b1;
    tick();
    check("clearovr.overrun", 32'(ovr_v[0]), 32'd0);
    check("clearovr.valid_kept", 32'(v_v[0]), 32'd1);

    // drop coinciding with ClearOvr: the set must win
    pulse_start(0);
    wait_overrun(11, "setwins");
    tick();
    check("setwins.then_cleared", 32'(ovr_v[0]), 32'd0);
    check("setwins.data_kept", 32'(d_v[0]), 32'h0000_00A1);
    @(negedge Clock);
    clr_v[0] = 1'b0;
    ready_v[0] = 1'b1;
    tick();
    check("drain.valid_cleared", 32'(v_v[0]), 32'd0);

    // reset during the 4th SHIFT cycle
    p_a = 8'hA1;
    repeat (2) tick();
    pulse_start(0);
    repeat (5) tick();
    check("abort.busy_before", 32'(busy_a), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("abort.pl_n", 32'(pl_a), 32'd1);
    check("abort.clkinh", 32'(inh_a), 32'd1);
    check("abort.busy", 32'(busy_a), 32'd0);
    check("abort.valid", 32'(v_v[0]), 32'd0);
    check("abort.data", 32'(d_v[0]), 32'd0);
    check("abort.overrun", 32'(ovr_v[0]), 32'd0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    vcount = 0;
    repeat (20) begin
      tick();
      if (v_v[0]) vcount++;
    end
    check("abort.valid_never", vcount, 32'd0);
    pulse_start(0);
    sb_push(0, 16'h00A1);
    wait_frame(0, 11, "after_rst");

    // Q7b tap with inversion undone inside the receiver
    p_b = 8'hA1;
    ready_v[1] = 1'b1;
    pulse_start(1);
    sb_push(1, 16'h00A1);
    wait_frame(1, 11, "inv");

    // Start held high: one frame per return to IDLE
    repeat (2) tick();
    @(negedge Clock);
    start_v[1] = 1'b1;
    pulses = 0;
    frames = 0;
    idle_seen = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 60) start_v[1] = 1'b0;
      tick();
      if (!pl_v[1]) begin
        check("held.idle_between_loads", 32'(idle_seen), 32'd1);
        idle_seen = 1'b0;
        pulses++;
        sb_push(1, 16'h00A1);
      end
      if (!busy_v[1]) idle_seen = 1'b1;
      if (v_v[1]) begin
        frames++;
        sb_pop(1, "held");
      end
    end
    check("held.frames_eq_loads", frames, pulses);
    check("held.several_frames", 32'(pulses >= 3), 32'd1);
    check("held.sb_empty", 32'(exp_q.size()), 32'd0);

    // two cascaded chips, WIDTH=16
    p_c = 16'hA15E;
    ready_v[2] = 1'b1;
    pulse_start(2);
    sb_push(2, 16'hA15E);
    wait_frame(2, 19, "w16");
    tick();
    check("w16.valid_one_cycle", 32'(v_v[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_byte_receiver.md
SERIAL_BYTE_RECEIVER -- requirements
Module: serial_byte_receiver

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: bits per frame; 8 means one SN74LS165, 16 means two cascaded.
REQ-002 The block SHALL take parameter INVERT_IN, default 0: when 1, SerialIn is inverted before capture, for the Q7b tap.
REQ-003 Clock  input  1  single system clock; shared with the SN74LS165 Clock1 pin.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request one frame capture; level sampled on the rising edge of Clock.
REQ-006 SerialIn  input  1  the SN74LS165 Q7 output.
REQ-007 PL_n  output  1  active-low parallel load to the SN74LS165 PL pin.
REQ-008 ClkInh  output  1  clock inhibit to the SN74LS165 Clock2 pin; high holds the register.
REQ-009 Data  output  WIDTH  captured frame, MSB first: the first bit sampled lands in Data[WIDTH-1].
REQ-010 Valid  output  1  Data holds an unconsumed frame.
REQ-011 Ready  input  1  consumer accepts Data; a transfer occurs on a Clock edge where Valid and Ready are both 1.
REQ-012 Busy  output  1  a capture is in progress.
REQ-013 Overrun  output  1  sticky flag: a completed frame was dropped.
REQ-014 ClearOvr  input  1  synchronous clear of Overrun.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE: PL_n=1, ClkInh=1, Busy=0; Start=1 moves the FSM to LOAD.
REQ-017 LOAD: PL_n=0 and ClkInh=1 for exactly one cycle; BitCnt is cleared to 0; the FSM moves to SHIFT.
REQ-018 SHIFT: on each edge, the conditioned SerialIn SHALL shift into the internal shift register and BitCnt SHALL increment.
REQ-019 SHIFT: ClkInh=0 while BitCnt < WIDTH-1, and ClkInh=1 during the cycle with BitCnt = WIDTH-1; after WIDTH samples the FSM moves to DONE.
REQ-020 DONE: the shift register content is delivered to the output register (see REQ-022 to REQ-024); the FSM returns to IDLE after one cycle.
REQ-021 Busy SHALL be 1 in LOAD, SHIFT and DONE; Start is ignored while Busy=1.
REQ-022 Latency: Valid SHALL rise WIDTH+3 rising edges after the edge that samples Start.
REQ-023 Delivery in DONE with Valid=0, or with Valid=1 and Ready=1: Data is updated and Valid=1.
REQ-024 Delivery in DONE with Valid=1 and Ready=0: the new frame is discarded, Data is unchanged, and Overrun is set.
REQ-025 With Valid=1, Data and Valid SHALL stay stable until a transfer; a transfer with no concurrent delivery clears Valid.
REQ-026 Overrun SHALL clear on ClearOvr=1; if a set event and ClearOvr occur in the same cycle, the set wins.
REQ-027 BitCnt SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during a frame.
REQ-028 A new frame may start the cycle after DONE, even while Valid=1.

Reset
REQ-029 Reset_n=0 SHALL immediately force: state IDLE, PL_n=1, ClkInh=1, Busy=0, Valid=0, Data=0, Overrun=0, BitCnt=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no partial Data is ever presented.
REQ-031 After reset release, the first Start SHALL behave exactly as defined in REQ-016 to REQ-022.

Structure
REQ-032 Package sbr_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-033 The capture datapath (shift register, BitCnt, INVERT_IN conditioning) SHALL be a sub-module named sbr_shift_capture; the FSM and the output handshake stay in the top module.

Verification
REQ-034 The bench SHALL include a behavioural SN74LS165 model clocked by Clock and driven by PL_n, ClkInh and P inputs.
REQ-035 Scenario: P7..P0=1,0,1,0,0,0,0,1, Start pulse, Ready=1 -> Data=8'hA1, Valid for one cycle, Valid rises 11 edges after Start.
REQ-036 Scenario: frame 8'hA1 delivered and held (Ready=0), second frame 8'h5E captured -> Data stays 8'hA1, Overrun=1; ClearOvr -> Overrun=0.
REQ-037 Scenario: Reset_n pulsed low at the 4th SHIFT cycle -> all outputs at reset values, Valid never rises; next Start captures 8'hA1 correctly.
REQ-038 Scenario: INVERT_IN=1 with SerialIn tied to Q7b, P=8'hA1 -> Data=8'hA1; Start held high while Busy -> exactly one frame per IDLE entry.
REQ-039 Scenario: WIDTH=16 with two cascaded models holding 16'hA15E -> Data=16'hA15E, Valid rises 19 edges after Start.
